dqsw_wrlvl_ctrl: RTL and testbench
==================================

// Module: dqsw_wrlvl_ctrl
// PURPOSE
//  Write-leveling training controller for one DDR4 lane; drives the DQSW-training IOD of that lane.
//  Emits DQS pulses and samples the DRAM's DQ feedback. Steps the IOD TX delay line until the
//  feedback goes 0->1, then reports the winning tap. Sits between PHY training sequencer and lane IOD.
// PARAMETERS
//  TAP_W        8   width of tap counter / TAP_VALUE
//  MAX_TAPS     255 taps tried before FAIL (must be < 2**TAP_W)
//  FB_LATENCY   12  cycles from PULSE to first valid feedback sample (>=1)
//  SAMPLES      4   pulses per tap; feedback=1 only if all SAMPLES read 1 (1..15)
//  SETTLE       8   idle cycles after each delay-line move/load (>=1)
// PORTS
//  FAB_CLK                   in  1     fabric clock, all logic rising-edge
//  ARST_N                    in  1     async active-low reset
//  START                     in  1     1-cycle pulse; ignored unless BUSY=0
//  BUSY                      out 1     high from cycle after accepted START until DONE/ERROR
//  DONE                      out 1     1-cycle pulse on successful completion
//  ERROR                     out 1     1-cycle pulse on failure
//  TAP_VALUE                 out TAP_W trained tap; held until next START
//  TX_DATA_0                 out 2     DQS bit pair to IOD
//  OE_DATA_0                 out 2     DQS output-enable pair to IOD
//  ODT_EN_0                  out 1     fixed 0
//  EYE_MONITOR_CLEAR_FLAGS_0 out 1     fixed 0
//  DELAY_LINE_LOAD_0         out 1     1-cycle pulse, resets delay to base
//  DELAY_LINE_MOVE_0         out 1     1-cycle pulse, one tap step
//  DELAY_LINE_DIRECTION_0    out 1     1=increment; held 1 while BUSY, 0 otherwise
//  DELAY_LINE_OUT_OF_RANGE_0 in  1     IOD delay line saturated
//  RX_DATA_0                 in  2     DQ feedback pair; bit[0] is the sampled feedback
// BEHAVIOUR
//  Reset: all outputs 0, TAP_VALUE=0, state IDLE, tap_cnt=0, seen0=0.
//  States: IDLE, LOAD, SETTLE, PULSE, WAIT, SAMPLE, STEP, PASS, FAIL.
//  IDLE:   START -> LOAD; tap_cnt=0, seen0=0, samp_cnt=0, all1=1.
//  LOAD:   DELAY_LINE_LOAD_0=1 for exactly 1 cycle -> SETTLE.
//  SETTLE: count SETTLE cycles, outputs quiet -> PULSE.
//  PULSE:  1 cycle, TX_DATA_0=2'b01, OE_DATA_0=2'b11 -> WAIT. Otherwise both buses are 2'b00.
//  WAIT:   FB_LATENCY-1 cycles -> SAMPLE.
//  SAMPLE: all1 &= RX_DATA_0[0]; samp_cnt++.
//          samp_cnt<SAMPLES -> PULSE, else evaluate fb=all1:
//    fb=0            -> seen0=1; STEP.
//    fb=1 & seen0    -> TAP_VALUE=tap_cnt; PASS.
//    fb=1 & !seen0   -> STEP (started past the edge; keep scanning for a 0 first).
//  STEP:   tap_cnt==MAX_TAPS or OUT_OF_RANGE_0=1 -> FAIL.
//          Else DELAY_LINE_MOVE_0=1 for 1 cycle, tap_cnt++, reset samp_cnt/all1 -> SETTLE.
//  PASS:   DONE=1 for 1 cycle -> IDLE.
//  FAIL:   ERROR=1 for 1 cycle -> IDLE; TAP_VALUE unchanged.
//  OUT_OF_RANGE_0 is sampled in every non-IDLE state; if asserted, go to FAIL on the next edge
//   (overrides all other transitions).
//  START while BUSY is ignored.
//  LOAD and MOVE never assert in the same cycle.
//  MOVE is never issued while PULSE/WAIT/SAMPLE are in flight.
//  tap_cnt saturates; it never wraps.
//  ARST_N low mid-training: immediate return to reset values; no DONE/ERROR pulse.
//  Min cycles per tap = SETTLE + SAMPLES*(1+FB_LATENCY) + 1 (STEP).
// TESTING
//  T1 fb model: 0 for taps<37, 1 after; START -> DONE once, TAP_VALUE=37; 37 MOVE pulses, 1 LOAD.
//  T2 fb always 1 -> no 0 ever seen; after MAX_TAPS=255 moves, ERROR pulse, TAP_VALUE keeps old value.
//  T3 fb 1 at taps 0-4, 0 at taps 5-19, 1 from tap 20 -> DONE, TAP_VALUE=20.
//  T4 OUT_OF_RANGE_0 raised at tap 10 during WAIT -> ERROR next cycle; BUSY falls; no further MOVE.
//  T5 fb glitch: one of 4 samples is 0 at tap 30, clean 1 at tap 31 -> TAP_VALUE=31.
//  T6 ARST_N low during SETTLE at tap 50 -> all outputs 0 async; new START retrains from LOAD, tap 0.

Source files
------------

// File: rtl/dqsw_wrlvl_ctrl.sv
// ----------------------------------------------------------------------------
// dqsw_wrlvl_ctrl
// Write-leveling training controller for one DDR4 lane. It resets the lane's
// DQSW transmit delay line, sends DQS pulses, and samples the DQ feedback
// returned by the DRAM. It then steps the delay one tap at a time until the
// feedback has been seen at 0 and then reads back as 1. The tap where that
// happens is reported on TAP_VALUE.
//
// Ports
//   FAB_CLK                    in   fabric clock; all logic uses the rising edge
//   ARST_N                     in   asynchronous active-low reset
//   START                      in   one-cycle request; accepted only while BUSY=0
//   BUSY                       out  training in progress
//   DONE / ERROR               out  one-cycle completion / failure pulses
//   TAP_VALUE                  out  trained tap; held until the next success
//   TX_DATA_0 / OE_DATA_0      out  DQS bit pair and its output enables
//   ODT_EN_0                   out  tied 0
//   EYE_MONITOR_CLEAR_FLAGS_0  out  tied 0
//   DELAY_LINE_LOAD_0          out  one-cycle pulse; returns the delay to base
//   DELAY_LINE_MOVE_0          out  one-cycle pulse; moves the delay one tap
//   DELAY_LINE_DIRECTION_0     out  1 (increment) while BUSY
//   DELAY_LINE_OUT_OF_RANGE_0  in   delay line saturated; aborts training
//   RX_DATA_0                  in   DQ feedback; only bit 0 is used
// ----------------------------------------------------------------------------
module dqsw_wrlvl_ctrl #(
    parameter int TAP_W      = 8,
    parameter int MAX_TAPS   = 255,
    parameter int FB_LATENCY = 12,
    parameter int SAMPLES    = 4,
    parameter int SETTLE     = 8
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [TAP_W-1:0] TAP_VALUE,
    output logic [1:0]       TX_DATA_0,
    output logic [1:0]       OE_DATA_0,
    output logic             ODT_EN_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    input  logic [1:0]       RX_DATA_0
);

    // One down-counter serves both the settle and the feedback-wait intervals.
    localparam int CNT_MAX = (SETTLE > FB_LATENCY) ? SETTLE : FB_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'((FB_LATENCY >= 2) ? FB_LATENCY - 2 : 0);
    localparam logic [TAP_W-1:0] MAX_TAP_C = TAP_W'(MAX_TAPS);
    localparam logic [3:0]       SAMPLES_C = 4'(SAMPLES);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_PULSE, S_WAIT, S_SAMPLE, S_STEP, S_PASS, S_FAIL
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAP_W-1:0]   tap_cnt_q;
    logic [TAP_W-1:0]   tap_value_q;
    logic [3:0]         samp_cnt_q;
    logic               all1_q;
    logic               seen0_q;
    logic               busy_q, done_q, error_q, load_q, move_q;
    logic [1:0]         tx_q, oe_q;

    logic [3:0]         samp_cnt_d;
    logic               all1_d;
    logic               in_training;
    logic               unused_rx;

    assign samp_cnt_d  = samp_cnt_q + 4'd1;
    assign all1_d      = all1_q & RX_DATA_0[0];
    assign in_training = (state_q != S_IDLE) && (state_q != S_PASS) && (state_q != S_FAIL);
    assign unused_rx   = RX_DATA_0[1];

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tap_cnt_q   <= '0;
            tap_value_q <= '0;
            samp_cnt_q  <= '0;
            all1_q      <= 1'b0;
            seen0_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            tx_q        <= 2'b00;
            oe_q        <= 2'b00;
        end else begin
            // Pulse-type outputs are valid only in the cycle after they are set.
            done_q  <= 1'b0;
            error_q <= 1'b0;
            load_q  <= 1'b0;
            move_q  <= 1'b0;
            tx_q    <= 2'b00;
            oe_q    <= 2'b00;

            if (in_training && DELAY_LINE_OUT_OF_RANGE_0) begin
                // A saturated delay line aborts training from any training state.
                state_q <= S_FAIL;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    // PASS/FAIL already show BUSY=0, so a START there is accepted.
                    S_IDLE, S_PASS, S_FAIL: begin
                        if (START) begin
                            state_q    <= S_LOAD;
                            tap_cnt_q  <= '0;
                            seen0_q    <= 1'b0;
                            samp_cnt_q <= '0;
                            all1_q     <= 1'b1;
                            load_q     <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_LOAD: begin
                        state_q <= S_SETTLE;
                        cnt_q   <= SETTLE_LD;
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= S_PULSE;
                            tx_q    <= 2'b01;
                            oe_q    <= 2'b11;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_PULSE: begin
                        // With a one-cycle feedback latency there is no wait interval.
                        if (FB_LATENCY < 2) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LD;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == '0) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        all1_q     <= all1_d;
                        samp_cnt_q <= samp_cnt_d;
                        if (samp_cnt_d < SAMPLES_C) begin
                            state_q <= S_PULSE;
                            tx_q    <= 2'b01;
                            oe_q    <= 2'b11;
                        end else if (all1_d && seen0_q) begin
                            state_q     <= S_PASS;
                            tap_value_q <= tap_cnt_q;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            // A 1 seen before any 0 means the scan started
                            // past the edge, so scanning continues.
                            if (!all1_d) begin
                                seen0_q <= 1'b1;
                            end
                            state_q <= S_STEP;
                            // MOVE shows in the STEP cycle itself, except on the last tap.
                            move_q  <= (tap_cnt_q != MAX_TAP_C);
                        end
                    end
                    S_STEP: begin
                        if (tap_cnt_q == MAX_TAP_C) begin
                            state_q <= S_FAIL;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_SETTLE;
                            cnt_q      <= SETTLE_LD;
                            tap_cnt_q  <= tap_cnt_q + TAP_W'(1);
                            samp_cnt_q <= '0;
                            all1_q     <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign BUSY                      = busy_q;
    assign DONE                      = done_q;
    assign ERROR                     = error_q;
    assign TAP_VALUE                 = tap_value_q;
    assign TX_DATA_0                 = tx_q;
    assign OE_DATA_0                 = oe_q;
    assign ODT_EN_0                  = 1'b0;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;
    assign DELAY_LINE_LOAD_0         = load_q;
    assign DELAY_LINE_MOVE_0         = move_q;
    assign DELAY_LINE_DIRECTION_0    = busy_q;

endmodule

// File: tb/tb_dqsw_wrlvl_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dqsw_wrlvl_ctrl
// Scoreboard bench for the write-leveling controller. The stimulus pushes
// the expected outcome of each training run into exp_q: the result kind,
// TAP_VALUE, the MOVE count and the LOAD count. A monitor counts the
// delay-line pulses. On every DONE or ERROR pulse it pops one entry from
// exp_q and compares it with what it observed. Direct spot checks, such as
// reset values and BUSY after START, are queued in chk_q and compared by
// the same monitor. A small IOD model tracks the tap position from LOAD and
// MOVE, and returns feedback from a per-test lookup function.
// ----------------------------------------------------------------------------
module tb_dqsw_wrlvl_ctrl;

    localparam int TAP_W      = 8;
    localparam int MAX_TAPS   = 255;
    localparam int FB_LATENCY = 12;
    localparam int SAMPLES    = 4;
    localparam int SETTLE     = 8;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, error;
    logic [TAP_W-1:0] tap_value;
    logic [1:0]       tx, oe;
    logic             odt, eye_clr, dl_load, dl_move, dl_dir;
    logic             oor;
    logic [1:0]       rx;

    always #5 clk = ~clk;

    dqsw_wrlvl_ctrl #(
        .TAP_W(TAP_W), .MAX_TAPS(MAX_TAPS), .FB_LATENCY(FB_LATENCY),
        .SAMPLES(SAMPLES), .SETTLE(SETTLE)
    ) dut (
        .FAB_CLK(clk),
        .ARST_N(arst_n),
        .START(start),
        .BUSY(busy),
        .DONE(done),
        .ERROR(error),
        .TAP_VALUE(tap_value),
        .TX_DATA_0(tx),
        .OE_DATA_0(oe),
        .ODT_EN_0(odt),
        .EYE_MONITOR_CLEAR_FLAGS_0(eye_clr),
        .DELAY_LINE_LOAD_0(dl_load),
        .DELAY_LINE_MOVE_0(dl_move),
        .DELAY_LINE_DIRECTION_0(dl_dir),
        .DELAY_LINE_OUT_OF_RANGE_0(oor),
        .RX_DATA_0(rx)
    );

    typedef struct {
        logic       is_done;
        int         tap;
        int         moves;
        int         loads;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    int   mode = 0;
    int   tap_pos = 0;
    int   pcnt = 0;
    int   mov_cnt = 0;
    int   load_cnt = 0;

    // IOD model: the tap position follows LOAD/MOVE, and pcnt counts the DQS
    // pulses sent at the current tap.
    always @(posedge clk) begin
        if (dl_load) begin
            tap_pos <= 0;
            pcnt    <= 0;
        end else if (dl_move) begin
            tap_pos <= tap_pos + 1;
            pcnt    <= 0;
        end else if (tx == 2'b01 && oe == 2'b11) begin
            pcnt <= pcnt + 1;
        end
    end

    // Feedback returned per test: m = test mode, t = tap, p = pulses sent at this tap.
    function automatic logic fb(int m, int t, int p);
        case (m)
            1:       return (t >= 37);
            2:       return 1'b1;
            3:       return (t < 5) || (t >= 20);
            5:       return (t >= 31) || (t == 30 && p != 3);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        rx  = {1'b0, fb(mode, tap_pos, pcnt)};
        oor = (mode == 4) && (tap_pos == 10) && (pcnt >= 1);
    end

    function automatic void cmp(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        if (!arst_n) begin
            mov_cnt  = 0;
            load_cnt = 0;
        end else begin
            if (start && !busy) begin
                mov_cnt  = 0;
                load_cnt = 0;
            end
            if (dl_move) mov_cnt++;
            if (dl_load) load_cnt++;
            if (done || error) begin
                n_txn++;
                $display("txn %0d: %s tap=%0d moves=%0d loads=%0d", n_txn,
                         done ? "DONE" : "ERROR", tap_value, mov_cnt, load_cnt);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_completion: got done=%0d error=%0d, expected none",
                             done, error);
                end else begin
                    e = exp_q.pop_front();
                    cmp("result_is_done", int'(done), int'(e.is_done));
                    cmp("result_is_error", int'(error), int'(!e.is_done));
                    cmp("tap_value", int'(tap_value), e.tap);
                    cmp("move_pulses", mov_cnt, e.moves);
                    cmp("load_pulses", load_cnt, e.loads);
                    cmp("busy_at_end", int'(busy), 0);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_tap"}, int'(tap_value), 0);
        chk({tag, "_tx"}, int'(tx), 0);
        chk({tag, "_oe"}, int'(oe), 0);
        chk({tag, "_load"}, int'(dl_load), 0);
        chk({tag, "_move"}, int'(dl_move), 0);
        chk({tag, "_dir"}, int'(dl_dir), 0);
        chk({tag, "_odt"}, int'(odt), 0);
        chk({tag, "_eye"}, int'(eye_clr), 0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 40000) begin
            @(negedge clk);
            if (done || error) seen = 1'b1;
            n++;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string tag, input int m, input logic is_done, input int tap,
                       input int moves, input bit extra_start);
        exp_t e;
        mode = m;
        e.is_done = is_done;
        e.tap     = tap;
        e.moves   = moves;
        e.loads   = 1;
        exp_q.push_back(e);
        pulse_start();
        @(negedge clk);
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        chk({tag, "_dir_while_busy"}, int'(dl_dir), 1);
        if (extra_start) begin
            // START while busy must not restart training (loads stays 1).
            repeat (100) @(posedge clk);
            pulse_start();
        end
        wait_end(tag);
    endtask

    initial begin
        int n;
        #12;
        check_quiet("reset");
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);

        run("t1", 1, 1'b1, 37, 37, 1'b1);
        run("t2", 2, 1'b0, 37, 255, 1'b0);
        run("t3", 3, 1'b1, 20, 20, 1'b0);
        run("t4", 4, 1'b0, 20, 10, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_no_move_after_error", mov_cnt, 10);
        run("t5", 5, 1'b1, 31, 31, 1'b0);

        // T6: reset during SETTLE at tap 50, then retrain from the start.
        mode = 6;
        pulse_start();
        n = 0;
        while (tap_pos != 50 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_tap50", tap_pos, 50);
        #2 arst_n = 1'b0;
        #1;
        check_quiet("t6_async_reset");
        repeat (4) @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        run("t6_retrain", 1, 1'b1, 37, 37, 1'b0);

        chk("expected_queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
